control_sequencer: RTL and testbench

Parametrised micro-operation sequencer for the 8-bit SAP CPU; it replaces the fixed six-stage controller. It decodes the instruction-register opcode into a 16-bit registered control word, one word per T-state. It adds an immediate load, flag-conditional jumps, a latched halt state and variable-length instructions. It sits between the IR/flags register and every datapath load/enable pin.

---
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : SAP CPU micro-op sequencer: one registered 16-bit control word
//            per T-state, falling-edge clocked.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int OPCODE_W  = 4,
    parameter int EARLY_END = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                carry_flag,
    output logic [15:0]         ctrl,
    output logic [2:0]          stage,
    output logic                instr_done,
    output logic                halted
);

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_HALT = 3'd6,
        ST_RST  = 3'd7
    } state_t;

    localparam logic [15:0] C_IDLE     = 16'h0FE3;
    localparam logic [15:0] C_JUMP     = 16'h1FA3;
    localparam logic [15:0] C_IR_ADDR  = 16'h07A3;

    localparam logic [3:0] C_OP_HLT = 4'h0;
    localparam logic [3:0] C_OP_NOP = 4'h1;
    localparam logic [3:0] C_OP_ADD = 4'h2;
    localparam logic [3:0] C_OP_SUB = 4'h3;
    localparam logic [3:0] C_OP_LDA = 4'h4;
    localparam logic [3:0] C_OP_OUT = 4'h5;
    localparam logic [3:0] C_OP_STA = 4'h6;
    localparam logic [3:0] C_OP_JMP = 4'h7;
    localparam logic [3:0] C_OP_LDI = 4'h8;
    localparam logic [3:0] C_OP_JZ  = 4'h9;
    localparam logic [3:0] C_OP_JC  = 4'hA;

    state_t      r_stage;
    logic [15:0] r_ctrl;
    logic        r_done;
    logic        r_halted;

    logic        w_undef;
    logic [3:0]  w_op;
    state_t      w_last;
    state_t      w_next;
    logic [15:0] w_word;
    logic        w_done;

    // Opcodes beyond the 4-bit map fold onto NOP
    generate
        if (OPCODE_W > 4) begin : g_wide_opcode
            assign w_undef = |opcode[OPCODE_W-1:4];
        end else begin : g_narrow_opcode
            assign w_undef = 1'b0;
        end
    endgenerate

    assign w_op = w_undef ? C_OP_NOP : opcode[3:0];

    always_comb begin
        w_last = ST_T5;
        if (EARLY_END != 0) begin
            case (w_op)
                C_OP_ADD, C_OP_SUB, C_OP_STA:                  w_last = ST_T5;
                C_OP_LDA:                                      w_last = ST_T4;
                C_OP_OUT, C_OP_JMP, C_OP_LDI, C_OP_JZ, C_OP_JC: w_last = ST_T3;
                default:                                       w_last = ST_T2;
            endcase
        end
    end

    always_comb begin
        w_next = r_stage;
        case (r_stage)
            ST_RST:  w_next = ST_T0;
            ST_HALT: w_next = ST_HALT;
            ST_T2: begin
                if (w_op == C_OP_HLT)
                    w_next = ST_HALT;
                else if (w_last == ST_T2)
                    w_next = ST_T0;
                else
                    w_next = ST_T3;
            end
            default: begin
                if (r_stage == w_last)
                    w_next = ST_T0;
                else
                    w_next = state_t'(r_stage + 3'd1);
            end
        endcase
    end

    // Words are decoded for the stage being entered so ctrl always matches stage
    always_comb begin
        w_word = C_IDLE;
        case (w_next)
            ST_T0: w_word = 16'h27E3;
            ST_T1: w_word = 16'h4FE3;
            ST_T2: w_word = 16'h0D63;
            ST_T3: begin
                case (w_op)
                    C_OP_ADD, C_OP_SUB, C_OP_LDA, C_OP_STA: w_word = C_IR_ADDR;
                    C_OP_OUT: w_word = 16'h0FF2;
                    C_OP_JMP: w_word = C_JUMP;
                    C_OP_LDI: w_word = 16'h0F83;
                    C_OP_JZ:  w_word = zero_flag  ? C_JUMP : C_IDLE;
                    C_OP_JC:  w_word = carry_flag ? C_JUMP : C_IDLE;
                    default:  w_word = C_IDLE;
                endcase
            end
            ST_T4: begin
                case (w_op)
                    C_OP_ADD, C_OP_SUB: w_word = 16'h0DE1;
                    C_OP_LDA:           w_word = 16'h0DC3;
                    C_OP_STA:           w_word = 16'h0BF3;
                    default:            w_word = C_IDLE;
                endcase
            end
            ST_T5: begin
                case (w_op)
                    C_OP_ADD: w_word = 16'h8FC7;
                    C_OP_SUB: w_word = 16'h8FCF;
                    C_OP_STA: w_word = 16'h0EE3;
                    default:  w_word = C_IDLE;
                endcase
            end
            default: w_word = C_IDLE;
        endcase
    end

    // HLT completes in T2 regardless of EARLY_END
    assign w_done = (w_next == w_last) || ((w_next == ST_T2) && (w_op == C_OP_HLT));

    always_ff @(negedge clk) begin
        if (!resetn) begin
            r_stage  <= ST_RST;
            r_ctrl   <= C_IDLE;
            r_done   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_stage  <= w_next;
            r_ctrl   <= w_word;
            r_done   <= w_done;
            r_halted <= (w_next == ST_HALT);
        end
    end

    assign ctrl       = r_ctrl;
    assign stage      = r_stage;
    assign instr_done = r_done;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Scoreboard bench for two sequencer configurations sharing reset/flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic        clk;
    logic        resetn;
    logic        zero_flag;
    logic        carry_flag;
    logic [3:0]  opcode_a;
    logic [5:0]  opcode_b;
    logic [15:0] ctrl_a, ctrl_b;
    logic [2:0]  stage_a, stage_b;
    logic        done_a, done_b, halted_a, halted_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    control_sequencer #(.OPCODE_W(4), .EARLY_END(1)) u_dut_a (
        .clk(clk), .resetn(resetn), .opcode(opcode_a),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .ctrl(ctrl_a), .stage(stage_a), .instr_done(done_a), .halted(halted_a)
    );

    control_sequencer #(.OPCODE_W(6), .EARLY_END(0)) u_dut_b (
        .clk(clk), .resetn(resetn), .opcode(opcode_b),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .ctrl(ctrl_b), .stage(stage_b), .instr_done(done_b), .halted(halted_b)
    );

    typedef struct packed {
        logic [2:0]  stage;
        logic [15:0] ctrl;
        logic        done;
        logic        halted;
    } resp_t;

    localparam int P_RST  = -1;
    localparam int P_HALT = 6;

    resp_t q_a[$];
    resp_t q_b[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Position of the final stage of an instruction, counted from T0
    function automatic int last_pos(int op, bit early);
        if (op == 0) return 2;
        if (!early) return 5;
        case (op)
            2, 3, 6:          return 5;
            4:                return 4;
            5, 7, 8, 9, 10:   return 3;
            default:          return 2;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(int op, int pos, bit z, bit c);
        logic [15:0] w;
        w = 16'h0FE3;
        case (pos)
            0: w = 16'h27E3;
            1: w = 16'h4FE3;
            2: w = 16'h0D63;
            3: case (op)
                   2, 3, 4, 6: w = 16'h07A3;
                   5:          w = 16'h0FF2;
                   7:          w = 16'h1FA3;
                   8:          w = 16'h0F83;
                   9:          w = z ? 16'h1FA3 : 16'h0FE3;
                   10:         w = c ? 16'h1FA3 : 16'h0FE3;
                   default:    w = 16'h0FE3;
               endcase
            4: case (op)
                   2, 3:    w = 16'h0DE1;
                   4:       w = 16'h0DC3;
                   6:       w = 16'h0BF3;
                   default: w = 16'h0FE3;
               endcase
            5: case (op)
                   2:       w = 16'h8FC7;
                   3:       w = 16'h8FCF;
                   6:       w = 16'h0EE3;
                   default: w = 16'h0FE3;
               endcase
            default: w = 16'h0FE3;
        endcase
        return w;
    endfunction

    function automatic int next_pos(int pos, int op, bit early);
        if (pos == P_RST) return 0;
        if (pos == P_HALT) return P_HALT;
        if (pos == 2 && op == 0) return P_HALT;
        if (pos == last_pos(op, early)) return 0;
        return pos + 1;
    endfunction

    function automatic resp_t expect_at(int pos, int op, bit early, bit z, bit c);
        resp_t r;
        if (pos == P_RST) begin
            r.stage = 3'd7; r.ctrl = 16'h0FE3; r.done = 1'b0; r.halted = 1'b0;
        end else if (pos == P_HALT) begin
            r.stage = 3'd6; r.ctrl = 16'h0FE3; r.done = 1'b0; r.halted = 1'b1;
        end else begin
            r.stage  = 3'(pos);
            r.ctrl   = exp_word(op, pos, z, c);
            r.done   = (pos == last_pos(op, early));
            r.halted = 1'b0;
        end
        return r;
    endfunction

    task automatic compare(input string name, input resp_t got, input resp_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got stage=%0d ctrl=%h done=%b halted=%b, expected stage=%0d ctrl=%h done=%b halted=%b",
                     name, $time, got.stage, got.ctrl, got.done, got.halted,
                     exp.stage, exp.ctrl, exp.done, exp.halted);
        end
    endtask

    // Monitor: every falling edge presents one response per DUT
    initial begin
        resp_t got;
        forever begin
            @(negedge clk);
            #1;
            if (q_a.size() > 0) begin
                got.stage = stage_a; got.ctrl = ctrl_a; got.done = done_a; got.halted = halted_a;
                compare("dut_a", got, q_a.pop_front());
            end
            if (q_b.size() > 0) begin
                got.stage = stage_b; got.ctrl = ctrl_b; got.done = done_b; got.halted = halted_b;
                compare("dut_b", got, q_b.pop_front());
            end
        end
    end

    // Stimulus: opcodes change only at T0 (or freely while in RST/HALT)
    initial begin
        int  pos_a, pos_b, op_a, op_b, halt_a, halt_b;
        bit  sta_reset_done, rst;
        int  script_a[$];
        int  script_b[$];
        script_a = '{1, 2, 3, 9, 9, 9, 10, 10, 10, 4, 5, 6, 7, 8, 6, 0};
        script_b = '{5, 34, 1, 2, 3, 0};
        pos_a = P_RST; pos_b = P_RST;
        op_a = 1; op_b = 1;
        halt_a = 0; halt_b = 0;
        sta_reset_done = 1'b0;
        resetn = 1'b0; zero_flag = 1'b0; carry_flag = 1'b0;
        opcode_a = 4'd0; opcode_b = 6'd0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            if (pos_a == 0) begin
                if (script_a.size() > 0) op_a = script_a.pop_front();
                else op_a = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 15));
            end else if (pos_a == P_RST || pos_a == P_HALT) begin
                op_a = int'($urandom_range(0, 15));
            end
            if (pos_b == 0) begin
                if (script_b.size() > 0) op_b = script_b.pop_front();
                else op_b = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 63));
            end else if (pos_b == P_RST || pos_b == P_HALT) begin
                op_b = int'($urandom_range(0, 63));
            end
            opcode_a = 4'(op_a);
            opcode_b = 6'(op_b);

            halt_a = (pos_a == P_HALT) ? halt_a + 1 : 0;
            halt_b = (pos_b == P_HALT) ? halt_b + 1 : 0;
            rst = (cyc < 2) || (halt_a >= 20) || (halt_b >= 20) ||
                  ($urandom_range(0, 149) == 0);
            // Abort the first STA in T4 so its RAM write must never appear
            if (!sta_reset_done && pos_a == 4 && op_a == 6) begin
                rst = 1'b1;
                sta_reset_done = 1'b1;
            end
            resetn     = ~rst;
            zero_flag  = 1'($urandom_range(0, 1));
            carry_flag = 1'($urandom_range(0, 1));

            pos_a = rst ? P_RST : next_pos(pos_a, op_a, 1'b1);
            pos_b = rst ? P_RST : next_pos(pos_b, op_b, 1'b0);
            q_a.push_back(expect_at(pos_a, op_a, 1'b1, zero_flag, carry_flag));
            q_b.push_back(expect_at(pos_b, op_b, 1'b0, zero_flag, carry_flag));
        end

        @(negedge clk);
        #2;
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d responses pending, expected 0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
